// File: rtl/serial_mag_comp_ctrl.sv
// Serial magnitude comparator sequencer: walks a 2-bit compare slice over two captured
// operands, MSB pair first, with valid/ready hand-shaking on operand and result sides.
module serial_mag_comp_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             busy
);

    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              decided_q, decided_d;
    logic              rec_lt_q, rec_lt_d;
    logic              rec_gt_q, rec_gt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;

    logic [1:0]        sa_s;
    logic [1:0]        sb_s;
    logic              uneq_s;

    function automatic logic [1:0] slice_of(input logic [WIDTH-1:0] v, input logic [IW-1:0] i);
        return v[{i, 1'b0} +: 2];
    endfunction

    assign sa_s   = slice_of(a_q, idx_q);
    assign sb_s   = slice_of(b_q, idx_q);
    assign uneq_s = (sa_s != sb_s);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            idx_q     <= {IW{1'b0}};
            decided_q <= 1'b0;
            rec_lt_q  <= 1'b0;
            rec_gt_q  <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            rec_lt_q  <= rec_lt_d;
            rec_gt_q  <= rec_gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
        end
    end

    // Next-state and result logic; the first unequal slice owns the verdict,
    // and the output flags are loaded only on entry to DONE.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        rec_lt_d  = rec_lt_q;
        rec_gt_d  = rec_gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d       = a;
                    b_d       = b;
                    idx_d     = IW'(NS - 1);
                    decided_d = 1'b0;
                    rec_lt_d  = 1'b0;
                    rec_gt_d  = 1'b0;
                    state_d   = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                if (uneq_s && !decided_q) begin
                    rec_lt_d  = (sa_s < sb_s);
                    rec_gt_d  = (sa_s > sb_s);
                    decided_d = 1'b1;
                end else begin
                    decided_d = decided_q;
                end
                if ((EARLY_EXIT && uneq_s) || (idx_q == {IW{1'b0}})) begin
                    state_d = S_DONE;
                    eq_d    = !(decided_q || uneq_s);
                    lt_d    = decided_q ? rec_lt_q : (sa_s < sb_s);
                    gt_d    = decided_q ? rec_gt_q : (sa_s > sb_s);
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
                gt_d    = 1'b0;
            end
        endcase
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign eq          = eq_q;
    assign lt          = lt_q;
    assign gt          = gt_q;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Self-checking bench: one early-exit and one fixed-latency instance, checked against
// an arithmetic reference model of verdict and latency.
module tb_serial_mag_comp_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sv_s   [2];
    logic       sr_s   [2];
    logic [7:0] a_s    [2];
    logic [7:0] b_s    [2];
    logic       rv_s   [2];
    logic       rr_s   [2];
    logic       eq_s   [2];
    logic       lt_s   [2];
    logic       gt_s   [2];
    logic       busy_s [2];

    int n_checks;
    int n_errors;

    serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv_s[0]), .start_ready(sr_s[0]),
        .a(a_s[0]), .b(b_s[0]),
        .res_valid(rv_s[0]), .res_ready(rr_s[0]),
        .eq(eq_s[0]), .lt(lt_s[0]), .gt(gt_s[0]), .busy(busy_s[0])
    );

    serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_fl (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv_s[1]), .start_ready(sr_s[1]),
        .a(a_s[1]), .b(b_s[1]),
        .res_valid(rv_s[1]), .res_ready(rr_s[1]),
        .eq(eq_s[1]), .lt(lt_s[1]), .gt(gt_s[1]), .busy(busy_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected latency: position from MSB of first differing bit pair, or full walk.
    function automatic int ref_k(input logic [7:0] x, input logic [7:0] y, input int ee);
        int xa, yb;
        if (ee == 0) return 4;
        for (int j = 0; j < 4; j++) begin
            xa = (int'(x) / (1 << (6 - 2 * j))) % 4;
            yb = (int'(y) / (1 << (6 - 2 * j))) % 4;
            if (xa != yb) return j + 1;
        end
        return 4;
    endfunction

    // Full transaction on instance sel; stall = DONE cycles with res_ready low.
    task automatic run_op(input int sel, input logic [7:0] x, input logic [7:0] y,
                          input int stall, input bit flood);
        logic [2:0] exp_r;
        logic [2:0] got_r;
        int exp_k;
        int k;
        exp_r = {x == y, x < y, x > y};
        exp_k = ref_k(x, y, (sel == 0) ? 1 : 0);
        @(negedge clk);
        n_checks++;
        if (sr_s[sel] !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_ready sel=%0d got=%b want=1", sel, sr_s[sel]);
        end
        sv_s[sel] = 1'b1; a_s[sel] = x; b_s[sel] = y;
        rr_s[sel] = 1'($urandom_range(0, 1));
        @(negedge clk);
        sv_s[sel] = 1'b0;
        a_s[sel]  = 8'($urandom); b_s[sel] = 8'($urandom);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            rr_s[sel] = (stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end while (!rv_s[sel] && k < 20);
        n_checks++;
        if (k !== exp_k || rv_s[sel] !== 1'b1) begin
            n_errors++;
            $display("FAIL latency sel=%0d a=%h b=%h got=%0d rv=%b want=%0d", sel, x, y, k, rv_s[sel], exp_k);
        end
        rr_s[sel] = (stall == 0) ? 1'b1 : 1'b0;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            if (flood) begin
                sv_s[sel] = 1'b1; a_s[sel] = 8'($urandom); b_s[sel] = 8'($urandom);
            end
            got_r = {eq_s[sel], lt_s[sel], gt_s[sel]};
            n_checks++;
            if (got_r !== exp_r || rv_s[sel] !== 1'b1 || sr_s[sel] !== 1'b0 || busy_s[sel] !== 1'b1) begin
                n_errors++;
                $display("FAIL result sel=%0d a=%h b=%h cyc=%0d got eq/lt/gt=%b rv=%b sr=%b busy=%b want %b 1 0 1",
                         sel, x, y, s, got_r, rv_s[sel], sr_s[sel], busy_s[sel], exp_r);
            end
        end
        sv_s[sel] = 1'b0;
        rr_s[sel] = 1'b1;
        @(negedge clk);
        rr_s[sel] = 1'($urandom_range(0, 1));
        got_r = {eq_s[sel], lt_s[sel], gt_s[sel]};
        n_checks++;
        if (rv_s[sel] !== 1'b0 || got_r !== 3'b000 || sr_s[sel] !== 1'b1 || busy_s[sel] !== 1'b0) begin
            n_errors++;
            $display("FAIL release sel=%0d got rv=%b flags=%b sr=%b busy=%b want 0 000 1 0",
                     sel, rv_s[sel], got_r, sr_s[sel], busy_s[sel]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({sr_s[i], rv_s[i], eq_s[i], lt_s[i], gt_s[i], busy_s[i]} !== 6'b100000) begin
                n_errors++;
                $display("FAIL %s sel=%0d got sr/rv/eq/lt/gt/busy=%b want 100000", tag, i,
                         {sr_s[i], rv_s[i], eq_s[i], lt_s[i], gt_s[i], busy_s[i]});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sv_s[i] = 1'b0; rr_s[i] = 1'b0; a_s[i] = 8'h00; b_s[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");
    endtask

    task automatic test_directed();
        for (int i = 0; i < 2; i++) begin
            run_op(i, 8'hA5, 8'hA5, 0, 1'b0);
            run_op(i, 8'hC0, 8'h40, 0, 1'b0);
            run_op(i, 8'h12, 8'h13, 1, 1'b0);
            run_op(i, 8'h13, 8'h12, 2, 1'b0);
            run_op(i, 8'h00, 8'hFF, 10, 1'b1);
            run_op(i, 8'hFF, 8'hFF, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        sv_s[0] = 1'b1; a_s[0] = 8'h5A; b_s[0] = 8'h5A;
        @(negedge clk);
        sv_s[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 8'h7F, 8'h80, 0, 1'b0);
        run_op(1, 8'h7F, 8'h80, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 2; i++) begin
                x = 8'($urandom);
                y = ($urandom_range(0, 7) == 0) ? x : 8'($urandom);
                if ($urandom_range(0, 3) == 0) y = {x[7:2], 2'($urandom)};
                run_op(i, x, y, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
